rc4_ksa_engine: RTL and testbench
=================================

# rc4_ksa_engine

Parametrised RC4 key-scheduling engine that combines state-array initialisation (S[i] = i) and the key-driven swap shuffle into a single FSM. It drives one single-port synchronous S-memory (1-cycle read latency) and replaces the separate init and shuffle blocks. It is generalised in state-array size and key length, and adds an optional skip-init mode that re-shuffles whatever the memory already holds. A decrypt or PRGA block sits downstream on `done`.

## Interface
Parameters:
- ADDR_W, 8, state width; array depth N = 2^ADDR_W; each S entry and each key byte is ADDR_W bits
- KEY_BYTES, 3, key length in bytes; must be ≥ 1

Ports:
- clk  in  1  sole clock; everything is rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- skip_init  in  1  sampled with start; 1 = skip the INIT phase
- secret_key  in  KEY_BYTES*ADDR_W  key; byte 0 is the most significant ADDR_W bits; latched at start
- mem_q  in  ADDR_W  S-memory read data, valid the cycle after the address is presented
- mem_addr  out  ADDR_W  S-memory address
- mem_data  out  ADDR_W  S-memory write data
- mem_wr_en  out  1  S-memory write enable
- busy  out  1  high from the cycle after start is accepted until done, inclusive
- done  out  1  one-cycle completion strobe

## Operation
- States: IDLE, INIT, RD_I, CAP_I, RD_J, CAP_J, WR_I, WR_J, DONE.
- IDLE:
  - If start = 1: latch secret_key, clear i, j and the key index k.
  - Next state is INIT when skip_init = 0, otherwise RD_I.
  - start while busy = 1 is ignored.
- INIT: write addr = i, data = i each cycle, then increment i. After i = N-1, clear i and go to RD_I.
- RD_I: mem_addr = i.
- CAP_I:
  - Register si = mem_q.
  - Register j ← (j + mem_q + key[k]) mod N. All adds are ADDR_W bits wide; carries are discarded.
- RD_J: mem_addr = j (the updated value).
- CAP_J: register sj = mem_q.
- WR_I: write S[i] = sj.
- WR_J: write S[j] = si.
  - k wraps to 0 after KEY_BYTES-1. Use a counter, not a modulo operator.
  - If i = N-1, go to DONE; otherwise increment i and k and go to RD_I.
- j = i is legal: both writes store si, so the entry is unchanged.
- DONE: done = 1 for one cycle, then return to IDLE.
- mem_wr_en is 1 only in INIT, WR_I and WR_J. mem_data = 0 whenever mem_wr_en = 0. mem_addr = 0 in IDLE and DONE.

## Timing
- All outputs are registered or derived from registered state.
- Reset values: mem_addr = 0, mem_data = 0, mem_wr_en = 0, busy = 0, done = 0. i, j, k and the FSM state are cleared (state to IDLE).
- Reset mid-operation:
  - The FSM is in IDLE the cycle after rst is sampled, with no write in that cycle.
  - Memory contents are left as-is.
  - rst has priority over start in the same cycle.
- Start accepted at edge t:
  - INIT writes occur in cycles t+1 … t+N.
  - Each shuffle iteration takes exactly 6 cycles.
  - done is high in cycle t+7N+1 (skip_init = 1: t+6N+1); for N = 256 that is t+1793.
- A new start is accepted in the cycle after done at the earliest. start sampled in the DONE cycle is ignored.
- Key changes after acceptance have no effect until the next start.

## Test plan
- Default parameters (ADDR_W = 8, KEY_BYTES = 3), key = 24'h000249, skip_init = 0, RAM model with 1-cycle latency -> done exactly 1793 cycles after start. Dumping all 256 entries gives a permutation of 0..255 that matches the golden software KSA.
- ADDR_W = 2, KEY_BYTES = 1, key = 2'd1 -> final S = [0,2,3,1]. done at t+29. mem_wr_en high for exactly 12 cycles.
- ADDR_W = 2, KEY_BYTES = 2, key = 4'b01_00 (byte0 = 1, byte1 = 0) -> final S = [2,0,1,3]. This checks key byte ordering, k wrap, and the j = i self-swaps at i = 1 and i = 3.
- ADDR_W = 2, KEY_BYTES = 1, key = 0, memory preloaded [3,2,1,0], skip_init = 1 -> no INIT writes, final S = [0,3,1,2], done at t+25.
- rst asserted 10 cycles into the shuffle -> next cycle busy = 0, mem_wr_en = 0, no done. A fresh start then produces the correct full result.
- start pulsed again while busy, and key changed mid-run -> ignored. Result and done timing are identical to an undisturbed run.

Source files
------------

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: fills S[i] = i (unless skipped), then runs the
// key-driven swap shuffle against a single-port, 1-cycle-latency S-memory.
module rc4_ksa_engine #(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          skip_init,
  input  logic [KEY_BYTES*ADDR_W-1:0]   secret_key,
  input  logic [ADDR_W-1:0]             mem_q,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [ADDR_W-1:0]             mem_data,
  output logic                          mem_wr_en,
  output logic                          busy,
  output logic                          done
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [ADDR_W-1:0] I_LAST = {ADDR_W{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_RD_I, S_CAP_I, S_RD_J, S_CAP_J, S_WR_I, S_WR_J, S_DONE
  } state_t;

  state_t                        state_q;
  logic [KEY_BYTES*ADDR_W-1:0]   key_q;
  logic [ADDR_W-1:0]             i_q, j_q, si_q;
  logic [KW-1:0]                 k_q;
  logic [ADDR_W-1:0]             mem_addr_q, mem_data_q;
  logic                          mem_wr_en_q, busy_q, done_q;

  logic [ADDR_W-1:0]             key_byte;
  logic [ADDR_W-1:0]             j_d;
  logic                          k_last;

  // Key byte 0 occupies the most significant ADDR_W bits of the latched key.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (k_q == KW'(b)) key_byte = key_q[(KEY_BYTES-1-b)*ADDR_W +: ADDR_W];
    end
  end

  assign j_d    = j_q + mem_q + key_byte;
  assign k_last = (k_q == KW'(KEY_BYTES-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      si_q        <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_wr_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mem_wr_en_q <= 1'b0;
      mem_data_q  <= '0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          mem_addr_q <= '0;
          if (start) begin
            key_q  <= secret_key;
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            busy_q <= 1'b1;
            if (!skip_init) begin
              state_q     <= S_INIT;
              mem_wr_en_q <= 1'b1;
            end else begin
              state_q <= S_RD_I;
            end
          end
        end
        S_INIT: begin
          if (i_q == I_LAST) begin
            i_q        <= '0;
            mem_addr_q <= '0;
            state_q    <= S_RD_I;
          end else begin
            i_q         <= i_q + 1'b1;
            mem_addr_q  <= i_q + 1'b1;
            mem_data_q  <= i_q + 1'b1;
            mem_wr_en_q <= 1'b1;
          end
        end
        S_RD_I: state_q <= S_CAP_I;
        S_CAP_I: begin
          si_q       <= mem_q;
          j_q        <= j_d;
          mem_addr_q <= j_d;
          state_q    <= S_RD_J;
        end
        S_RD_J: state_q <= S_CAP_J;
        // mem_data_q carries S[j] into the WR_I cycle.
        S_CAP_J: begin
          mem_addr_q  <= i_q;
          mem_data_q  <= mem_q;
          mem_wr_en_q <= 1'b1;
          state_q     <= S_WR_I;
        end
        S_WR_I: begin
          mem_addr_q  <= j_q;
          mem_data_q  <= si_q;
          mem_wr_en_q <= 1'b1;
          state_q     <= S_WR_J;
        end
        S_WR_J: begin
          k_q <= k_last ? '0 : k_q + 1'b1;
          if (i_q == I_LAST) begin
            mem_addr_q <= '0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            i_q        <= i_q + 1'b1;
            mem_addr_q <= i_q + 1'b1;
            state_q    <= S_RD_I;
          end
        end
        S_DONE: begin
          mem_addr_q <= '0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_wr_en = mem_wr_en_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: three instances (8/3, 2/1, 2/2) share start/rst and
// run against bench RAM models; final S arrays are checked against a software KSA.
module tb_rc4_ksa_engine;

  logic clk = 1'b0;
  logic rst, start, skip;
  always #5 clk = ~clk;

  logic [23:0] b_key;
  logic [7:0]  b_q, b_addr, b_data;
  logic        b_wr, b_busy, b_done;
  logic [1:0]  k1, s1_q, s1_addr, s1_data;
  logic        s1_wr, s1_busy, s1_done;
  logic [3:0]  k2;
  logic [1:0]  s2_q, s2_addr, s2_data;
  logic        s2_wr, s2_busy, s2_done;

  rc4_ksa_engine #(.ADDR_W(8), .KEY_BYTES(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .skip_init(skip), .secret_key(b_key),
    .mem_q(b_q), .mem_addr(b_addr), .mem_data(b_data), .mem_wr_en(b_wr),
    .busy(b_busy), .done(b_done));
  rc4_ksa_engine #(.ADDR_W(2), .KEY_BYTES(1)) dut_s1 (
    .clk(clk), .rst(rst), .start(start), .skip_init(skip), .secret_key(k1),
    .mem_q(s1_q), .mem_addr(s1_addr), .mem_data(s1_data), .mem_wr_en(s1_wr),
    .busy(s1_busy), .done(s1_done));
  rc4_ksa_engine #(.ADDR_W(2), .KEY_BYTES(2)) dut_s2 (
    .clk(clk), .rst(rst), .start(start), .skip_init(skip), .secret_key(k2),
    .mem_q(s2_q), .mem_addr(s2_addr), .mem_data(s2_data), .mem_wr_en(s2_wr),
    .busy(s2_busy), .done(s2_done));

  // RAM models with a bench-side preload port
  logic [7:0] b_mem [256];
  logic [1:0] s1_mem [4];
  logic [1:0] s2_mem [4];
  logic       pl_en;
  logic [7:0] pl_idx, b_pl;
  logic [1:0] s1_pl, s2_pl;

  always @(posedge clk) begin
    if (pl_en) b_mem[pl_idx] <= b_pl;
    else if (b_wr) b_mem[b_addr] <= b_data;
    b_q <= b_mem[b_addr];
    if (pl_en && pl_idx < 8'd4) begin
      s1_mem[pl_idx[1:0]] <= s1_pl;
      s2_mem[pl_idx[1:0]] <= s2_pl;
    end else begin
      if (s1_wr) s1_mem[s1_addr] <= s1_data;
      if (s2_wr) s2_mem[s2_addr] <= s2_data;
    end
    s1_q <= s1_mem[s1_addr];
    s2_q <= s2_mem[s2_addr];
  end

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pl_b [256];
  logic [1:0] pl_1 [4];
  logic [1:0] pl_2 [4];
  int g_s [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Software KSA on g_s; with sk=1 the caller has loaded g_s with the memory image.
  task automatic golden(input int n, input int aw, input int kb, input logic [23:0] key, input bit sk);
    int j, kv, t;
    j = 0;
    if (!sk) for (int x = 0; x < n; x++) g_s[x] = x;
    for (int x = 0; x < n; x++) begin
      kv = int'(key >> ((kb - 1 - (x % kb)) * aw)) & (n - 1);
      j = (j + g_s[x] + kv) % n;
      t = g_s[x];
      g_s[x] = g_s[j];
      g_s[j] = t;
    end
  endtask

  task automatic preload(input bit rev);
    for (int x = 0; x < 256; x++) begin
      @(negedge clk);
      pl_en  = 1'b1;
      pl_idx = 8'(x);
      pl_b[x] = 8'($urandom);
      b_pl   = pl_b[x];
      if (x < 4) begin
        pl_1[x] = rev ? 2'(3 - x) : 2'($urandom);
        pl_2[x] = 2'($urandom);
        s1_pl   = pl_1[x];
        s2_pl   = pl_2[x];
      end
    end
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic run(input logic [23:0] bk, input logic [1:0] kk1, input logic [3:0] kk2,
                     input bit sk, input bit disturb);
    int lat_b = 0, lat_1 = 0, lat_2 = 0;
    int nd_b = 0, nd_1 = 0, nd_2 = 0;
    int w_b = 0, w_1 = 0, w_2 = 0;
    for (int x = 0; x < 256; x++) g_s[x] = int'(pl_b[x]);
    golden(256, 8, 3, bk, sk);
    for (int x = 0; x < 256; x++) exp_q.push_back(8'(g_s[x]));
    for (int x = 0; x < 4; x++) g_s[x] = int'(pl_1[x]);
    golden(4, 2, 1, {22'd0, kk1}, sk);
    for (int x = 0; x < 4; x++) exp_q.push_back(8'(g_s[x]));
    for (int x = 0; x < 4; x++) g_s[x] = int'(pl_2[x]);
    golden(4, 2, 2, {20'd0, kk2}, sk);
    for (int x = 0; x < 4; x++) exp_q.push_back(8'(g_s[x]));

    @(negedge clk);
    b_key = bk; k1 = kk1; k2 = kk2; skip = sk; start = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 2000; n++) begin
      start = 1'b0;
      if (b_wr)  w_b++;
      if (s1_wr) w_1++;
      if (s2_wr) w_2++;
      if (b_done)  begin nd_b++; if (lat_b == 0) lat_b = n; end
      if (s1_done) begin nd_1++; if (lat_1 == 0) lat_1 = n; end
      if (s2_done) begin nd_2++; if (lat_2 == 0) lat_2 = n; end
      if (disturb) begin
        if (lat_1 != 0 && n == lat_1 + 1) check("s1_start_in_done_ignored", 32'(s1_busy), 32'd0);
        if (n == 5 || n == 20 || s1_done) begin
          start = 1'b1;
          b_key = 24'($urandom); k1 = 2'($urandom); k2 = 4'($urandom); skip = 1'($urandom);
        end
      end
      if (lat_b != 0 && n >= lat_b + 3) break;
      @(negedge clk);
    end
    start = 1'b0;

    check("lat_big", lat_b, sk ? 32'd1537 : 32'd1793);
    check("lat_s1",  lat_1, sk ? 32'd25 : 32'd29);
    check("lat_s2",  lat_2, sk ? 32'd25 : 32'd29);
    check("done_pulses_big", nd_b, 32'd1);
    check("done_pulses_s1",  nd_1, 32'd1);
    check("done_pulses_s2",  nd_2, 32'd1);
    check("wr_cycles_big", w_b, sk ? 32'd512 : 32'd768);
    check("wr_cycles_s1",  w_1, sk ? 32'd8 : 32'd12);
    check("wr_cycles_s2",  w_2, sk ? 32'd8 : 32'd12);
    check("busy_after_big", 32'(b_busy), 32'd0);
    for (int x = 0; x < 256; x++) check($sformatf("big_S[%0d]", x), 32'(b_mem[x]), 32'(exp_q.pop_front()));
    for (int x = 0; x < 4; x++) check($sformatf("s1_S[%0d]", x), 32'(s1_mem[x]), 32'(exp_q.pop_front()));
    for (int x = 0; x < 4; x++) check($sformatf("s2_S[%0d]", x), 32'(s2_mem[x]), 32'(exp_q.pop_front()));
  endtask

  task automatic reset_mid();
    int nd;
    nd = 0;
    @(negedge clk);
    b_key = 24'h123456; skip = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 266; n++) @(negedge clk);
    check("busy_before_rst", 32'(b_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 32'(b_busy), 32'd0);
    check("rst_mid_wr",   32'(b_wr),   32'd0);
    check("rst_mid_done", 32'(b_done), 32'd0);
    check("rst_mid_addr", 32'(b_addr), 32'd0);
    check("rst_mid_data", 32'(b_data), 32'd0);
    for (int n = 0; n < 20; n++) begin
      if (b_done) nd++;
      @(negedge clk);
    end
    check("rst_mid_no_done", nd, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; skip = 1'b0; pl_en = 1'b0;
    b_key = '0; k1 = '0; k2 = '0;
    pl_idx = '0; b_pl = '0; s1_pl = '0; s2_pl = '0;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(b_addr), 32'd0);
    check("rst_data", 32'(b_data), 32'd0);
    check("rst_wr",   32'(b_wr),   32'd0);
    check("rst_busy", 32'(b_busy), 32'd0);
    check("rst_done", 32'(b_done), 32'd0);
    check("rst_s1_busy", 32'(s1_busy), 32'd0);
    rst = 1'b0;

    preload(1'b0);
    run(24'h000249, 2'd1, 4'b0100, 1'b0, 1'b0);
    preload(1'b1);
    run(24'($urandom), 2'd0, 4'($urandom), 1'b1, 1'b0);
    reset_mid();
    run(24'h5a17c3, 2'd1, 4'b0100, 1'b0, 1'b0);
    preload(1'b0);
    run(24'h000249, 2'd1, 4'b0100, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
